approx_final_adder_pipe: RTL and testbench
==========================================

Name: approx_final_adder_pipe

Overview:
- Final carry-propagate stage of the approximate multiplier, directly downstream of the compression tree (OR-based carry-only compressors plus sum rows).
- Consumes the two remaining WIDTH-bit rows and adds them in a 2-stage split-carry pipeline with valid/ready handshake.
- Emits the product and a carry-out flag.
- Optionally replaces the low bits with an OR-merge, matching the carry-only approximation style.

Parameters:
- WIDTH, 16, row and product width (2x operand width of an 8x8 multiplier).
- SPLIT, 8, bit index where the carry chain is cut between stage 1 and stage 2; 1 <= SPLIT <= WIDTH-1.
- APPROX_BITS, 4, number of LSBs OR-merged when APPROX_LOW_OR_EN is defined; 0 <= APPROX_BITS <= SPLIT.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  rows valid.
- in_ready  out  1  stage accepts rows.
- in_row_a  in  WIDTH  sum row from compression tree.
- in_row_b  in  WIDTH  carry row from compression tree.
- out_valid  out  1  product valid.
- out_ready  in  1  consumer accepts product.
- out_product  out  WIDTH  (row_a + row_b) mod 2^WIDTH.
- out_cout  out  1  carry out of bit WIDTH-1.

Behaviour:
- Reset (async assert, sync release on clk): s1_valid=0, s2_valid=0, out_valid=0, out_product=0, out_cout=0, all stage data registers cleared. in_ready is 1 once reset deasserts.
- Stage 1 (S1) registers:
  - low sum {c_split, a[SPLIT-1:0]+b[SPLIT-1:0]}, i.e. SPLIT+1 bits;
  - a[WIDTH-1:SPLIT] and b[WIDTH-1:SPLIT].
- Stage 2 (S2) registers:
  - out_product = {a_hi + b_hi + c_split, low_sum[SPLIT-1:0]};
  - out_cout = carry of that upper add.
- out_valid = s2_valid. out_product and out_cout are driven straight from the S2 registers, with no combinational path from inputs.
- Load enables:
  - s2_load = s1_valid && (!s2_valid || out_ready).
  - s1_load = in_valid && in_ready.
  - in_ready = !s1_valid || s2_load. This is a combinational path out_ready -> in_ready; accepted.
- Valid updates:
  - s2_valid: set on s2_load; cleared when out_ready && !s2_load.
  - s1_valid: set on s1_load; cleared when s2_load && !s1_load.
- Latency: an accepted input appears on out_valid 2 cycles later if there is no backpressure. Throughput is 1 per cycle.
- Data in S1/S2 holds stable while its stage is not loaded. out_product/out_cout must not change while out_valid && !out_ready.
- Simultaneous events:
  - Accept, advance and output in the same cycle is legal. Full throughput with out_ready=1.
  - Both stages full and out_ready=0: in_ready=0 and no data is lost.
- Ordering: strict FIFO order, with no reordering or duplication.
- Reset mid-operation: both in-flight items are discarded and out_valid drops immediately on rst_n assertion.
- Width rule: the upper add is WIDTH-SPLIT+1 bits wide, and its MSB becomes out_cout.

Optional Feature:
- Macro: APPROX_LOW_OR_EN.
- Defined: bits [APPROX_BITS-1:0] of low_sum = a|b, computed bitwise. The carry into bit APPROX_BITS is forced to 0. Bits [SPLIT-1:APPROX_BITS] are added exactly.
- Undefined: exact addition over all bits.
- Handshake and latency are identical in both cases.

Decomposition:
- Package approx_mult_pkg:
  - PROD_WIDTH = 16, SPLIT_POS = 8, APPROX_LSB = 4 constants;
  - typedef row_t as logic [PROD_WIDTH-1:0].
- Sub-module approx_split_adder: combinational (n+1)-bit adder slice with carry-in, carry-out and an approximate-LSB count input. Instantiated once per stage.

Test Plan:
- Exact carry across split: a=0x00FF, b=0x0001, out_ready=1 -> out_product=0x0100, out_cout=0, out_valid exactly 2 cycles after acceptance.
- Overflow: a=0xFFFF, b=0x0001 -> out_product=0x0000, out_cout=1. Also a=0x8000, b=0x8000 -> 0x0000, out_cout=1.
- APPROX_LOW_OR_EN with APPROX_BITS=4:
  - a=0x000F, b=0x0001 -> 0x000F (exact build gives 0x0010);
  - a=0x0010, b=0x0010 -> 0x0020 in both builds.
- Backpressure:
  - Stimulus: stream 4 items (1+1, 2+2, 3+3, 4+4) with out_ready=0 for 5 cycles.
  - Expected while held: in_ready=0 after 2 accepts; out_product held at 0x0002.
  - Expected after release: outputs 0x0002, 0x0004, 0x0006, 0x0008 in order, one per cycle, with no loss or duplication.
- Reset mid-flight: 2 items in the pipe, rst_n=0 for 1 cycle -> out_valid=0 immediately and the items are lost. A new 0x1234+0x0001 then yields 0x1235.
- Random soak: 10k random a/b with random in_valid/out_ready -> scoreboard matches the (a+b) reference model (or the OR-low model when APPROX_LOW_OR_EN is defined). Also checks stability while stalled.

Source files
------------

// File: rtl/approx_mult_pkg.sv
// Shared constants and types for the approximate multiplier datapath.
package approx_mult_pkg;

  localparam int unsigned PROD_WIDTH = 16;
  localparam int unsigned SPLIT_POS  = 8;
  localparam int unsigned APPROX_LSB = 4;

  typedef logic [PROD_WIDTH-1:0] row_t;

endpackage

// File: rtl/approx_split_adder.sv
// Combinational N-bit adder slice with carry-in/carry-out.
// The lowest i_approx_cnt bits are OR-merged instead of added, and the
// carry leaving that region (including any carry-in) is forced to zero.
module approx_split_adder #(
  parameter int unsigned N  = 8,
  parameter int unsigned CW = $clog2(N + 1)
) (
  input  logic [N-1:0]  i_a,
  input  logic [N-1:0]  i_b,
  input  logic          i_cin,
  input  logic [CW-1:0] i_approx_cnt,
  output logic [N-1:0]  o_sum,
  output logic          o_cout
);

  logic w_c;

  // Bitwise ripple: OR-merge in the approximate region, full add above it.
  always_comb begin
    w_c   = i_cin;
    o_sum = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (CW'(i) < i_approx_cnt) begin
        o_sum[i] = i_a[i] | i_b[i];
        w_c      = 1'b0;
      end else begin
        o_sum[i] = i_a[i] ^ i_b[i] ^ w_c;
        w_c      = (i_a[i] & i_b[i]) | (w_c & (i_a[i] ^ i_b[i]));
      end
    end
    o_cout = w_c;
  end

endmodule

// File: rtl/approx_final_adder_pipe.sv
// Final carry-propagate stage of the approximate multiplier: adds the two
// compressed rows in a 2-stage split-carry pipeline with valid/ready.
// Optional macro APPROX_LOW_OR_EN: OR-merge the APPROX_BITS lowest bits.
module approx_final_adder_pipe
  import approx_mult_pkg::*;
#(
  parameter int unsigned WIDTH       = PROD_WIDTH,
  parameter int unsigned SPLIT       = SPLIT_POS,
  parameter int unsigned APPROX_BITS = APPROX_LSB
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_row_a,
  input  logic [WIDTH-1:0] in_row_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_product,
  output logic             out_cout
);

  localparam int unsigned HI_W  = WIDTH - SPLIT;
  localparam int unsigned LO_CW = $clog2(SPLIT + 1);
  localparam int unsigned HI_CW = $clog2(HI_W + 1);

`ifdef APPROX_LOW_OR_EN
  localparam bit APPROX_EN = 1'b1;
`else
  localparam bit APPROX_EN = 1'b0;
`endif

  logic             r_s1_valid;
  logic             r_s2_valid;
  logic [SPLIT:0]   r_low_sum;
  logic [HI_W-1:0]  r_a_hi;
  logic [HI_W-1:0]  r_b_hi;
  logic [WIDTH-1:0] r_product;
  logic             r_cout;

  logic             w_s1_load;
  logic             w_s2_load;
  logic [LO_CW-1:0] w_lo_approx_cnt;
  logic [SPLIT-1:0] w_lo_sum;
  logic             w_lo_cout;
  logic [HI_W-1:0]  w_hi_sum;
  logic             w_hi_cout;

  assign w_s2_load = r_s1_valid && (!r_s2_valid || out_ready);
  assign in_ready  = !r_s1_valid || w_s2_load;
  assign w_s1_load = in_valid && in_ready;

  assign w_lo_approx_cnt = APPROX_EN ? LO_CW'(APPROX_BITS) : '0;

  approx_split_adder #(.N(SPLIT), .CW(LO_CW)) u_lo_add (
    .i_a          (in_row_a[SPLIT-1:0]),
    .i_b          (in_row_b[SPLIT-1:0]),
    .i_cin        (1'b0),
    .i_approx_cnt (w_lo_approx_cnt),
    .o_sum        (w_lo_sum),
    .o_cout       (w_lo_cout)
  );

  approx_split_adder #(.N(HI_W), .CW(HI_CW)) u_hi_add (
    .i_a          (r_a_hi),
    .i_b          (r_b_hi),
    .i_cin        (r_low_sum[SPLIT]),
    .i_approx_cnt ('0),
    .o_sum        (w_hi_sum),
    .o_cout       (w_hi_cout)
  );

  // Stage valid flags: each stage fills on load and empties when drained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else begin
      if (w_s1_load)      r_s1_valid <= 1'b1;
      else if (w_s2_load) r_s1_valid <= 1'b0;
      if (w_s2_load)      r_s2_valid <= 1'b1;
      else if (out_ready) r_s2_valid <= 1'b0;
    end
  end

  // Stage 1: low sum with split carry, upper operand halves held for stage 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_low_sum <= '0;
      r_a_hi    <= '0;
      r_b_hi    <= '0;
    end else if (w_s1_load) begin
      r_low_sum <= {w_lo_cout, w_lo_sum};
      r_a_hi    <= in_row_a[WIDTH-1:SPLIT];
      r_b_hi    <= in_row_b[WIDTH-1:SPLIT];
    end
  end

  // Stage 2: upper add absorbs the split carry; registers drive outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_product <= '0;
      r_cout    <= 1'b0;
    end else if (w_s2_load) begin
      r_product <= {w_hi_sum, r_low_sum[SPLIT-1:0]};
      r_cout    <= w_hi_cout;
    end
  end

  assign out_valid   = r_s2_valid;
  assign out_product = r_product;
  assign out_cout    = r_cout;

endmodule

// File: tb/tb_approx_final_adder_pipe.sv
// Self-checking bench for approx_final_adder_pipe (honours APPROX_LOW_OR_EN).
module tb_approx_final_adder_pipe;
  import approx_mult_pkg::*;

  localparam int unsigned AB = 4;

  logic  clk = 1'b0;
  logic  rst_n;
  logic  in_valid;
  logic  in_ready;
  row_t  in_row_a;
  row_t  in_row_b;
  logic  out_valid;
  logic  out_ready;
  row_t  out_product;
  logic  out_cout;

  int checks = 0;
  int errors = 0;
  logic [16:0] q[$];

  always #5 clk = ~clk;

  approx_final_adder_pipe #(
    .WIDTH       (16),
    .SPLIT       (8),
    .APPROX_BITS (AB)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_row_a    (in_row_a),
    .in_row_b    (in_row_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_product (out_product),
    .out_cout    (out_cout)
  );

  // Reference: {cout, product} from plain integer arithmetic.
  function automatic logic [16:0] ref_sum(input row_t a, input row_t b);
    int unsigned hi, lo, full;
`ifdef APPROX_LOW_OR_EN
    hi   = (int'(a) >> AB) + (int'(b) >> AB);
    lo   = int'(a | b) & ((1 << AB) - 1);
    full = (hi << AB) | lo;
`else
    hi   = 0;
    lo   = 0;
    full = int'(a) + int'(b);
`endif
    return full[16:0];
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chkp(input string tag, input logic [16:0] obs, input logic [16:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%05h expected=%05h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One item through an empty pipe with out_ready=1, checking latency.
  task automatic send_one(input string tag, input row_t a, input row_t b,
                          input logic [16:0] exp);
    in_row_a = a; in_row_b = b; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk1({tag, "_in_ready"}, in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    chk1({tag, "_lat1_valid"}, out_valid, 1'b0);
    tick();
    chk1({tag, "_lat2_valid"}, out_valid, 1'b1);
    chkp({tag, "_result"}, {out_cout, out_product}, exp);
    tick();
    chk1({tag, "_drained"}, out_valid, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_row_a = '0; in_row_b = '0;
    tick(); tick();
    chk1("rst_out_valid", out_valid, 1'b0);
    chkp("rst_product", {out_cout, out_product}, 17'h0);
    rst_n = 1'b1;
    #1;
    chk1("rst_in_ready", in_ready, 1'b1);
    tick();

    // Directed vectors
`ifdef APPROX_LOW_OR_EN
    send_one("split_carry", 16'h00FF, 16'h0001, 17'h000FF);
    send_one("ovf_ffff",    16'hFFFF, 16'h0001, 17'h0FFFF);
    send_one("ovf_8000",    16'h8000, 16'h8000, 17'h10000);
    send_one("or_low",      16'h000F, 16'h0001, 17'h0000F);
`else
    send_one("split_carry", 16'h00FF, 16'h0001, 17'h00100);
    send_one("ovf_ffff",    16'hFFFF, 16'h0001, 17'h10000);
    send_one("ovf_8000",    16'h8000, 16'h8000, 17'h10000);
    send_one("or_low",      16'h000F, 16'h0001, 17'h00010);
`endif
    send_one("bit4", 16'h0010, 16'h0010, 17'h00020);

    // Backpressure: out_ready low for 5 cycles while streaming 4 items
    out_ready = 1'b0;
    in_valid = 1'b1; in_row_a = 16'd1; in_row_b = 16'd1;
    tick();
    in_row_a = 16'd2; in_row_b = 16'd2;
    #1;
    chk1("bp_accept2", in_ready, 1'b1);
    tick();
    in_row_a = 16'd3; in_row_b = 16'd3;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk1("bp_in_ready_low", in_ready, 1'b0);
      chk1("bp_held_valid", out_valid, 1'b1);
      chkp("bp_held_product", {out_cout, out_product}, ref_sum(16'd1, 16'd1));
      tick();
    end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k < 2) begin
        in_valid = 1'b1;
        in_row_a = row_t'(k + 3); in_row_b = row_t'(k + 3);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (k < 2) chk1("bp_rel_in_ready", in_ready, 1'b1);
      chk1("bp_rel_valid", out_valid, 1'b1);
      chkp("bp_rel_product", {out_cout, out_product},
           ref_sum(row_t'(k + 1), row_t'(k + 1)));
      tick();
    end
    chk1("bp_empty", out_valid, 1'b0);

    // Reset with two items in flight
    out_ready = 1'b0; in_valid = 1'b1;
    in_row_a = 16'h0AAA; in_row_b = 16'h0555;
    tick();
    in_row_a = 16'h0101; in_row_b = 16'h0202;
    tick();
    in_valid = 1'b0;
    chk1("mid_full_valid", out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk1("mid_rst_drop", out_valid, 1'b0);
    tick();
    rst_n = 1'b1;
    #1;
    chk1("mid_after_valid", out_valid, 1'b0);
    chk1("mid_after_ready", in_ready, 1'b1);
    tick();
    send_one("post_rst", 16'h1234, 16'h0001, 17'h01235);

    // Random soak with scoreboard; stalled outputs must keep matching q[0]
    for (int n = 0; n < 10000; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_row_a  = row_t'($urandom);
      in_row_b  = row_t'($urandom);
      #1;
      if (q.size() == 0) begin
        chk1("soak_spurious_valid", out_valid, 1'b0);
      end else if (out_valid) begin
        chkp("soak_product", {out_cout, out_product}, q[0]);
      end
      if (out_valid && out_ready && q.size() != 0) void'(q.pop_front());
      if (in_valid && in_ready) q.push_back(ref_sum(in_row_a, in_row_b));
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      #1;
      if (q.size() == 0) begin
        chk1("drain_spurious_valid", out_valid, 1'b0);
      end else begin
        chk1("drain_valid", out_valid, 1'b1);
        chkp("drain_product", {out_cout, out_product}, q[0]);
        if (out_valid) void'(q.pop_front());
      end
      tick();
    end
    chk1("drain_queue_empty", (q.size() == 0), 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
